updown_counter_mod: RTL and testbench

//  Parametrised up/down counter with a run-time upper limit, programmable step and

---
 rtl/cnt_pkg.sv | 14 +
 rtl/cnt_next_calc.sv | 89 ++++++++
 rtl/updown_counter_mod.sv | 99 +++++++++
 tb/tb_updown_counter_mod.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cnt_pkg.sv
// Shared definitions for the up/down counter and the register-map blocks
// that drive its mode field.
//   mode_e : 2-bit overflow/underflow behaviour select.
//            MODE_RSVD (2'b11) behaves exactly like MODE_WRAP.
package cnt_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_e;

endpackage

// File: rtl/cnt_next_calc.sv
// Combinational next-count calculation for updown_counter_mod.
// Ports:
//   i_count      current count
//   i_step       increment/decrement amount (zero-extended)
//   i_limit      upper bound of the legal range 0..limit
//   i_updwn      1 = up, 0 = down
//   i_mode       overflow mode (see cnt_pkg::mode_e)
//   o_next_count count to load if this cycle counts
//   o_ovf_evt    overflow event (up direction past limit)
//   o_udf_evt    underflow event (down direction below 0)
//   o_done_evt   one-shot termination
module cnt_next_calc
  import cnt_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STEP_W = 8
) (
  input  logic [WIDTH-1:0]  i_count,
  input  logic [STEP_W-1:0] i_step,
  input  logic [WIDTH-1:0]  i_limit,
  input  logic              i_updwn,
  input  logic [1:0]        i_mode,
  output logic [WIDTH-1:0]  o_next_count,
  output logic              o_ovf_evt,
  output logic              o_udf_evt,
  output logic              o_done_evt
);

  localparam int unsigned XW = WIDTH + 1;

  // One guard bit so count+step can never silently wrap.
  logic [XW-1:0]    w_count_x;
  logic [XW-1:0]    w_step_x;
  logic [XW-1:0]    w_limit_x;
  logic [XW-1:0]    w_sum;
  logic [WIDTH-1:0] w_diff;
  mode_e            w_mode;

  assign w_count_x = XW'(i_count);
  assign w_step_x  = XW'(i_step);
  assign w_limit_x = XW'(i_limit);
  assign w_sum     = w_count_x + w_step_x;
  assign w_diff    = i_count - w_step_x[WIDTH-1:0];
  assign w_mode    = mode_e'(i_mode);

  always_comb begin
    o_next_count = i_count;
    o_ovf_evt    = 1'b0;
    o_udf_evt    = 1'b0;
    o_done_evt   = 1'b0;

    if (i_count > i_limit) begin
      // Limit was lowered under the count: clamp to limit in either
      // direction; only the up direction reports it as an overflow.
      o_next_count = i_limit;
      o_ovf_evt    = i_updwn;
      o_done_evt   = i_updwn && (w_mode == MODE_ONESHOT);
    end else if (i_updwn) begin
      if (w_sum > w_limit_x) begin
        o_ovf_evt = 1'b1;
        case (w_mode)
          MODE_SAT:     o_next_count = i_limit;
          MODE_ONESHOT: begin
            o_next_count = i_limit;
            o_done_evt   = 1'b1;
          end
          default:      o_next_count = '0;
        endcase
      end else begin
        o_next_count = w_sum[WIDTH-1:0];
      end
    end else begin
      if (w_count_x >= w_step_x) begin
        o_next_count = w_diff;
      end else begin
        o_udf_evt = 1'b1;
        case (w_mode)
          MODE_SAT:     o_next_count = '0;
          MODE_ONESHOT: begin
            o_next_count = '0;
            o_done_evt   = 1'b1;
          end
          default:      o_next_count = i_limit;
        endcase
      end
    end
  end

endmodule

// File: rtl/updown_counter_mod.sv
// Up/down counter with run-time limit, programmable step and
// wrap / saturate / one-shot overflow behaviour.
// Ports:
//   clk, areset        clock; asynchronous active-high reset
//   load, loaddata     synchronous load (clamped to limit)
//   en, updwn, step    count enable, direction, step size
//   limit              upper bound (range 0..limit)
//   mode               00 WRAP, 01 SAT, 10 ONESHOT, 11 WRAP
//   clr_flags          clears sticky ovf/udf (a same-cycle event wins)
//   count              registered count
//   tc                 one-cycle terminal-count pulse per event
//   ovf, udf           sticky overflow / underflow flags
//   done               one-shot finished; counting frozen until load/reset
module updown_counter_mod
  import cnt_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STEP_W = 8
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              load,
  input  logic [WIDTH-1:0]  loaddata,
  input  logic              en,
  input  logic              updwn,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  limit,
  input  logic [1:0]        mode,
  input  logic              clr_flags,
  output logic [WIDTH-1:0]  count,
  output logic              tc,
  output logic              ovf,
  output logic              udf,
  output logic              done
);

  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic             r_ovf;
  logic             r_udf;
  logic             r_done;

  logic [WIDTH-1:0] w_next_count;
  logic             w_ovf_evt;
  logic             w_udf_evt;
  logic             w_done_evt;
  logic             w_active;
  logic             w_ovf_set;
  logic             w_udf_set;

  cnt_next_calc #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) u_next (
    .i_count      (r_count),
    .i_step       (step),
    .i_limit      (limit),
    .i_updwn      (updwn),
    .i_mode       (mode),
    .o_next_count (w_next_count),
    .o_ovf_evt    (w_ovf_evt),
    .o_udf_evt    (w_udf_evt),
    .o_done_evt   (w_done_evt)
  );

  // A counting edge happens only when not loading, not frozen and step != 0.
  assign w_active  = en && !load && !r_done && (step != '0);
  assign w_ovf_set = w_active && w_ovf_evt;
  assign w_udf_set = w_active && w_udf_evt;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_count <= '0;
      r_tc    <= 1'b0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_tc <= 1'b0;
      if (load) begin
        r_count <= (loaddata > limit) ? limit : loaddata;
        r_done  <= 1'b0;
      end else if (w_active) begin
        r_count <= w_next_count;
        r_tc    <= w_ovf_evt || w_udf_evt;
        if (w_done_evt) r_done <= 1'b1;
      end
      r_ovf <= w_ovf_set || (r_ovf && !clr_flags);
      r_udf <= w_udf_set || (r_udf && !clr_flags);
    end
  end

  assign count = r_count;
  assign tc    = r_tc;
  assign ovf   = r_ovf;
  assign udf   = r_udf;
  assign done  = r_done;

endmodule

// File: tb/tb_updown_counter_mod.sv
module tb_updown_counter_mod;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned STEP_W = 4;

  logic              clk = 1'b0;
  logic              areset;
  logic              load;
  logic [WIDTH-1:0]  loaddata;
  logic              en;
  logic              updwn;
  logic [STEP_W-1:0] step;
  logic [WIDTH-1:0]  limit;
  logic [1:0]        mode;
  logic              clr_flags;
  logic [WIDTH-1:0]  count;
  logic              tc;
  logic              ovf;
  logic              udf;
  logic              done;

  int errors = 0;
  int checks = 0;

  // Reference model state, plain integers.
  int m_count;
  int m_tc, m_ovf, m_udf, m_done;

  always #5 clk = ~clk;

  updown_counter_mod #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) dut (
    .clk       (clk),
    .areset    (areset),
    .load      (load),
    .loaddata  (loaddata),
    .en        (en),
    .updwn     (updwn),
    .step      (step),
    .limit     (limit),
    .mode      (mode),
    .clr_flags (clr_flags),
    .count     (count),
    .tc        (tc),
    .ovf       (ovf),
    .udf       (udf),
    .done      (done)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".count"}, int'(count), m_count);
    check({tag, ".tc"},    int'(tc),    m_tc);
    check({tag, ".ovf"},   int'(ovf),   m_ovf);
    check({tag, ".udf"},   int'(udf),   m_udf);
    check({tag, ".done"},  int'(done),  m_done);
  endtask

  task automatic drive(input logic ld, input int ldd, input logic e, input logic up,
                       input int st, input int lim, input int md, input logic clr);
    load = ld; loaddata = WIDTH'(ldd); en = e; updwn = up;
    step = STEP_W'(st); limit = WIDTH'(lim); mode = 2'(md); clr_flags = clr;
  endtask

  // Behavioural model: one clock edge worth of the counter rules.
  task automatic model_edge();
    int c, lim, st, nc, eo, eu;
    c = m_count; lim = int'(limit); st = int'(step);
    eo = 0; eu = 0; nc = c;
    if (areset) begin
      m_count = 0; m_tc = 0; m_ovf = 0; m_udf = 0; m_done = 0;
      return;
    end
    if (load) begin
      m_count = (int'(loaddata) < lim) ? int'(loaddata) : lim;
      m_done = 0; m_tc = 0;
    end else if (en && m_done == 0 && st != 0) begin
      if (c > lim) begin
        nc = lim;
        if (updwn) begin eo = 1; if (mode == 2) m_done = 1; end
      end else if (updwn) begin
        if (c + st > lim) begin
          eo = 1;
          if (mode == 1) nc = lim;
          else if (mode == 2) begin nc = lim; m_done = 1; end
          else nc = 0;
        end else nc = c + st;
      end else begin
        if (c - st >= 0) nc = c - st;
        else begin
          eu = 1;
          if (mode == 1) nc = 0;
          else if (mode == 2) begin nc = 0; m_done = 1; end
          else nc = lim;
        end
      end
      m_count = nc;
      m_tc = eo | eu;
    end else begin
      m_tc = 0;
    end
    m_ovf = eo ? 1 : (clr_flags ? 0 : m_ovf);
    m_udf = eu ? 1 : (clr_flags ? 0 : m_udf);
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    m_count = 0; m_tc = 0; m_ovf = 0; m_udf = 0; m_done = 0;
    areset = 1'b1;
    drive(0, 0, 0, 1, 0, 255, 0, 0);
    tick("reset");
    areset = 1'b0;

    // 1: async reset mid-count
    drive(1, 'h37, 0, 1, 1, 255, 0, 0);
    tick("t1_load");
    drive(0, 0, 1, 1, 1, 255, 0, 0);
    #4;
    areset = 1'b1;
    m_count = 0; m_tc = 0; m_ovf = 0; m_udf = 0; m_done = 0;
    #1;
    check_all("t1_async");
    tick("t1_hold0");
    tick("t1_hold1");
    #2;
    areset = 1'b0;

    // 2: WRAP up limit 9 step 3, then down underflow
    drive(0, 0, 1, 1, 3, 9, 0, 0);
    tick("t2_up3");
    tick("t2_up6");
    tick("t2_up9");
    tick("t2_wrap");
    check("t2_wrap_abs", int'(count), 0);
    check("t2_wrap_tc", int'(tc), 1);
    drive(1, 1, 0, 0, 2, 9, 0, 0);
    tick("t2_load1");
    drive(0, 0, 1, 0, 2, 9, 0, 0);
    tick("t2_udf");
    check("t2_udf_abs", int'(count), 9);

    // 3: SAT up with repeated tc and clr/set collision
    drive(1, 190, 0, 1, 15, 200, 1, 1);
    tick("t3_load");
    drive(0, 0, 1, 1, 15, 200, 1, 0);
    tick("t3_sat");
    tick("t3_refire");
    drive(0, 0, 1, 1, 15, 200, 1, 1);
    tick("t3_clr_set");
    check("t3_ovf_kept", int'(ovf), 1);
    drive(0, 0, 0, 1, 15, 200, 1, 1);
    tick("t3_clr");

    // 4: ONESHOT down
    drive(1, 5, 0, 0, 2, 255, 2, 1);
    tick("t4_load");
    drive(0, 0, 1, 0, 2, 255, 2, 0);
    tick("t4_3");
    tick("t4_1");
    tick("t4_done");
    check("t4_done_abs", int'(done), 1);
    tick("t4_frozen");
    drive(1, 7, 0, 0, 2, 255, 2, 0);
    tick("t4_reload");

    // 5: load clamp, then limit lowered under count
    drive(1, 250, 0, 1, 1, 100, 0, 1);
    tick("t5_clamp");
    check("t5_clamp_abs", int'(count), 100);
    drive(0, 0, 0, 1, 1, 40, 0, 0);
    tick("t5_idle");
    drive(0, 0, 1, 1, 1, 40, 0, 0);
    tick("t5_lower_up");
    drive(1, 90, 0, 0, 1, 100, 0, 1);
    tick("t5_load90");
    drive(0, 0, 1, 0, 1, 20, 0, 0);
    tick("t5_lower_dn");

    // 6: load beats en, step 0 holds, en 0 holds
    drive(1, 33, 1, 1, 5, 100, 0, 0);
    tick("t6_load_en");
    drive(0, 0, 1, 1, 0, 100, 0, 0);
    tick("t6_step0");
    drive(0, 0, 0, 1, 5, 100, 0, 0);
    tick("t6_en0");

    // random
    limit = 8'd150;
    for (int i = 0; i < 400; i++) begin
      load      = ($urandom_range(0, 7) == 0);
      loaddata  = WIDTH'($urandom_range(0, 255));
      en        = ($urandom_range(0, 3) != 0);
      updwn     = $urandom_range(0, 1) == 1;
      step      = STEP_W'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) limit = WIDTH'($urandom_range(0, 255));
      mode      = 2'($urandom_range(0, 3));
      clr_flags = ($urandom_range(0, 7) == 0);
      tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
